// File: rtl/tinyodin_pkg.sv
// Shared types and helpers for the TTFS lane charger.
// Default lane geometry plus the saturating slope adder used by every slope row.
package tinyodin_pkg;

  localparam int unsigned LANES_DEF   = 8;
  localparam int unsigned W_DEF       = 4;
  localparam int unsigned SLOPE_W_DEF = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } charger_state_e;

  // Signed add clamped to a width-bit two's complement range.
  // The result is computed at 32 bits; callers narrow it to their slope width.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] slope,
                                                 input logic signed [31:0] weight,
                                                 input int unsigned        width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(slope) + 33'(weight);
    hi  = (33'sd1 <<< (width - 32'd1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) begin
      sat_add = 32'(hi);
    end else if (sum < lo) begin
      sat_add = 32'(lo);
    end else begin
      sat_add = 32'(sum);
    end
  endfunction

endpackage

// File: rtl/ttfs_lane_charger_if.sv
// Synapse-word input and charge-beat output handshakes of the lane charger.
interface ttfs_lane_charger_if
  import tinyodin_pkg::*;
#(
  parameter int unsigned N       = 256,
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned SLOPE_W = SLOPE_W_DEF
);
  localparam int unsigned ROWS  = N / LANES;
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam int unsigned IDX_W = $clog2(N);

  logic                      syn_valid_i;
  logic                      syn_ready_o;
  logic [ROW_W-1:0]          syn_row_i;
  logic [LANES*W-1:0]        syn_data_i;
  logic                      charge_valid_o;
  logic                      charge_ready_i;
  logic [IDX_W-1:0]          charge_idx_o;
  logic signed [SLOPE_W-1:0] charge_o;
  logic                      charge_done_o;

  modport slave (
    input  syn_valid_i, syn_row_i, syn_data_i, charge_ready_i,
    output syn_ready_o, charge_valid_o, charge_idx_o, charge_o, charge_done_o
  );

  modport master (
    output syn_valid_i, syn_row_i, syn_data_i, charge_ready_i,
    input  syn_ready_o, charge_valid_o, charge_idx_o, charge_o, charge_done_o
  );

endinterface

// File: rtl/ttfs_slope_row.sv
// One row of LANES signed slopes with per-lane saturating accumulate and clear.
module ttfs_slope_row
  import tinyodin_pkg::*;
#(
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned SLOPE_W = SLOPE_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr_i,
  input  logic                       we_i,
  input  logic [LANES*W-1:0]         data_i,
  output logic [LANES*SLOPE_W-1:0]   row_o
);

  logic signed [SLOPE_W-1:0] slope_q [LANES];
  logic signed [SLOPE_W-1:0] slope_d [LANES];

  // Clear wins over a write landing on the same row in the same cycle.
  always_comb begin
    for (int l = 0; l < int'(LANES); l++) begin
      slope_d[l] = slope_q[l];
      if (clr_i) begin
        slope_d[l] = '0;
      end else if (we_i) begin
        slope_d[l] = SLOPE_W'(sat_add(32'(slope_q[l]),
                                      32'($signed(data_i[l*W +: W])),
                                      SLOPE_W));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l < int'(LANES); l++) begin
        slope_q[l] <= '0;
      end
    end else begin
      for (int l = 0; l < int'(LANES); l++) begin
        slope_q[l] <= slope_d[l];
      end
    end
  end

  always_comb begin
    row_o = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      row_o[l*SLOPE_W +: SLOPE_W] = slope_q[l];
    end
  end

endmodule

// File: rtl/ttfs_lane_charger.sv
// Per-neuron charge slope store: accumulates synapse words LANES at a time and
// streams one signed charge per neuron on request.
module ttfs_lane_charger
  import tinyodin_pkg::*;
#(
  parameter int unsigned N       = 256,
  parameter int unsigned LANES   = LANES_DEF,
  parameter int unsigned W       = W_DEF,
  parameter int unsigned SLOPE_W = SLOPE_W_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clear_i,
  input  logic                charge_start_i,
  input  logic                tref_i,
  output logic                busy_o,
  ttfs_lane_charger_if.slave  bus
);

  localparam int unsigned ROWS   = N / LANES;
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam int unsigned LANE_W = $clog2(LANES);
  localparam int unsigned IDX_W  = $clog2(N);

  charger_state_e       state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [LANE_W-1:0]    lane_q, lane_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 syn_ready_q, syn_ready_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 accept;
  logic                 beat;
  logic                 last_beat;
  logic [LANES*SLOPE_W-1:0] row_data [ROWS];
  logic [LANES*SLOPE_W-1:0] sel_row;

  assign accept    = (state_q == ST_IDLE) && syn_ready_q && bus.syn_valid_i;
  assign beat      = valid_q && bus.charge_ready_i;
  assign last_beat = (row_q == ROW_W'(ROWS - 1)) && (lane_q == LANE_W'(LANES - 1));

  // The clear sweep walks row_q; accumulate targets the row named on the bus.
  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    ttfs_slope_row #(
      .LANES   (LANES),
      .W       (W),
      .SLOPE_W (SLOPE_W)
    ) u_row (
      .clk    (CLK),
      .rst    (RST),
      .clr_i  ((state_q == ST_CLEAR) && (row_q == ROW_W'(r))),
      .we_i   (accept && (bus.syn_row_i == ROW_W'(r))),
      .data_i (bus.syn_data_i),
      .row_o  (row_data[r])
    );
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          row_d   = '0;
          lane_d  = '0;
        end else if (charge_start_i) begin
          state_d = ST_SWEEP;
          row_d   = '0;
          lane_d  = '0;
        end
      end
      ST_CLEAR: begin
        if (clear_i) begin
          row_d = '0;
        end else if (row_q == ROW_W'(ROWS - 1)) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end
      ST_SWEEP: begin
        // Abort beats the pending handshake; the beat on this cycle is dropped.
        if (clear_i) begin
          state_d = ST_CLEAR;
          row_d   = '0;
          lane_d  = '0;
        end else if (beat) begin
          if (last_beat) begin
            state_d = ST_DONE;
            row_d   = '0;
            lane_d  = '0;
          end else if (lane_q == LANE_W'(LANES - 1)) begin
            lane_d = '0;
            row_d  = row_q + ROW_W'(1);
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (clear_i) begin
          state_d = ST_CLEAR;
          row_d   = '0;
          lane_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    syn_ready_d = (state_d == ST_IDLE);
    valid_d     = (state_d == ST_SWEEP);
    done_d      = (state_d == ST_DONE);
    idx_d       = IDX_W'(32'(row_d) * LANES + 32'(lane_d));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      lane_q      <= '0;
      idx_q       <= '0;
      syn_ready_q <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      lane_q      <= lane_d;
      idx_q       <= idx_d;
      syn_ready_q <= syn_ready_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Charge is read straight from the slope array so refractory gating is same-cycle.
  always_comb begin
    sel_row      = row_data[row_q];
    bus.charge_o = tref_i ? '0 : $signed(sel_row[32'(lane_q) * SLOPE_W +: SLOPE_W]);
  end

  assign bus.syn_ready_o    = syn_ready_q;
  assign bus.charge_valid_o = valid_q;
  assign bus.charge_idx_o   = idx_q;
  assign bus.charge_done_o  = done_q;
  assign busy_o             = busy_q;

endmodule
